// File: rtl/exe_muldiv_pkg.sv
// Shared constants for the RV32M multi-cycle execute unit: M-op funct3 codes,
// the M-type funct7 value, FSM encodings and operand-signedness helpers.
package exe_muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_M  = 7'b0000001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // rs1 is signed for MULH/MULHSU/DIV/REM; MUL's low half is sign-agnostic
    function automatic logic op1_signed(input logic [2:0] f3);
        return f3[2] ? !f3[0] : (f3 == MD_MULH || f3 == MD_MULHSU);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return f3[2] ? !f3[0] : (f3 == MD_MULH);
    endfunction

endpackage

// File: rtl/exe_muldiv_div_iter.sv
// Restoring radix-2 divider datapath on magnitudes: one quotient bit per step.
// Next-state quotient/remainder are exposed so the final step can be written back directly.
module exe_div_iter
    import exe_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_nxt_o,
    output logic [XLEN-1:0] rem_nxt_o,
    output logic            done_o
);

    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  divisor_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, divisor_q};
        if (diff[XLEN]) begin
            rem_nxt_o = shifted[XLEN-1:0];
            quo_nxt_o = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt_o = diff[XLEN-1:0];
            quo_nxt_o = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    assign done_o = step_i && (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else if (start_i) begin
            quo_q     <= dividend_i;
            rem_q     <= '0;
            divisor_q <= divisor_i;
            cnt_q     <= '0;
        end else if (step_i) begin
            quo_q     <= quo_nxt_o;
            rem_q     <= rem_nxt_o;
            cnt_q     <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/exe_muldiv.sv
// RV32M multi-cycle execute unit: accepts M-ops by valid/ready, stalls the pipe
// while iterating, and returns a registered one-cycle writeback.
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_FAST = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [4:0]      reg_waddr_o,
    output logic            reg_we_o,
    output logic [XLEN-1:0] reg_wdata_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [1:0]        state_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   op1_q;
    logic [XLEN-1:0]   op2_q;
    logic [4:0]        waddr_q;

    logic              accept;
    logic              fin;
    logic [XLEN-1:0]   fin_data;
    logic              in_s1;
    logic              in_s2;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [2*XLEN-1:0] mul_prod;
    logic              mul_last;
    logic [XLEN-1:0]   mul_res;
    logic              div_done;
    logic [XLEN-1:0]   quo_nxt;
    logic [XLEN-1:0]   rem_nxt;
    logic              div_zero;
    logic              div_ovf;
    logic              q_neg;
    logic              r_neg;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   div_spec;

    assign ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept  = valid_i && ready_o && !flush_i;
    assign stall_o = (state_q == ST_MUL) || (state_q == ST_DIV) || accept;

    assign in_s1 = op1_signed(funct3_i);
    assign in_s2 = op2_signed(funct3_i);
    assign mag1  = (in_s1 && op1_i[XLEN-1]) ? -op1_i : op1_i;
    assign mag2  = (in_s2 && op2_i[XLEN-1]) ? -op2_i : op2_i;

    generate
        if (MUL_FAST != 0) begin : g_mul_fast
            logic [2*XLEN-1:0] a_ext;
            logic [2*XLEN-1:0] b_ext;
            // Sign-extending to 2*XLEN makes the truncated unsigned product exact
            assign a_ext    = {{XLEN{op1_signed(f3_q) & op1_q[XLEN-1]}}, op1_q};
            assign b_ext    = {{XLEN{op2_signed(f3_q) & op2_q[XLEN-1]}}, op2_q};
            assign mul_prod = a_ext * b_ext;
            assign mul_last = 1'b1;
        end else begin : g_mul_iter
            logic [2*XLEN-1:0] mcand_q;
            logic [2*XLEN-1:0] acc_q;
            logic [2*XLEN-1:0] acc_nxt;
            logic [XLEN-1:0]   mplier_q;
            logic              neg_q;
            logic [CNT_W-1:0]  cnt_q;

            assign acc_nxt  = mplier_q[0] ? acc_q + mcand_q : acc_q;
            assign mul_prod = neg_q ? -acc_nxt : acc_nxt;
            assign mul_last = (cnt_q == CNT_W'(XLEN - 1));

            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    mcand_q  <= '0;
                    acc_q    <= '0;
                    mplier_q <= '0;
                    neg_q    <= 1'b0;
                    cnt_q    <= '0;
                end else if (accept && !funct3_i[2]) begin
                    mcand_q  <= {{XLEN{1'b0}}, mag1};
                    mplier_q <= mag2;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    neg_q    <= (in_s1 & op1_i[XLEN-1]) ^ (in_s2 & op2_i[XLEN-1]);
                end else if (state_q == ST_MUL) begin
                    acc_q    <= acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    assign mul_res = (f3_q == MD_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    exe_div_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (accept && funct3_i[2]),
        .step_i     (state_q == ST_DIV),
        .dividend_i (mag1),
        .divisor_i  (mag2),
        .quo_nxt_o  (quo_nxt),
        .rem_nxt_o  (rem_nxt),
        .done_o     (div_done)
    );

    assign div_zero = (op2_q == '0);
    assign div_ovf  = !f3_q[0] && (op1_q == {1'b1, {(XLEN-1){1'b0}}}) && (op2_q == '1);
    assign q_neg    = !f3_q[0] && (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
    assign r_neg    = !f3_q[0] && op1_q[XLEN-1];
    assign div_res  = f3_q[1] ? (r_neg ? -rem_nxt : rem_nxt)
                              : (q_neg ? -quo_nxt : quo_nxt);
    assign div_spec = div_zero ? (f3_q[1] ? op1_q : '1)
                               : (f3_q[1] ? '0 : op1_q);

    always_comb begin
        fin      = 1'b0;
        fin_data = '0;
        case (state_q)
            ST_MUL: begin
                fin      = mul_last;
                fin_data = mul_res;
            end
            ST_DIV: begin
                if (div_zero || div_ovf) begin
                    fin      = 1'b1;
                    fin_data = div_spec;
                end else begin
                    fin      = div_done;
                    fin_data = div_res;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            f3_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            waddr_q     <= '0;
            valid_o     <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else begin
            valid_o  <= 1'b0;
            reg_we_o <= 1'b0;
            if (flush_i) begin
                state_q <= ST_IDLE;
            end else if (accept) begin
                f3_q    <= funct3_i;
                op1_q   <= op1_i;
                op2_q   <= op2_i;
                waddr_q <= reg_waddr_i;
                state_q <= funct3_i[2] ? ST_DIV : ST_MUL;
            end else if (fin) begin
                reg_wdata_o <= fin_data;
                reg_waddr_o <= waddr_q;
                valid_o     <= 1'b1;
                reg_we_o    <= (waddr_q != '0);
                state_q     <= ST_DONE;
            end else if (state_q == ST_DONE) begin
                state_q <= ST_IDLE;
            end
        end
    end

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Parametrised multi-cycle execute unit for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
Sits beside the combinational execute stage. It takes M-type operations from id_exe through a valid/ready handshake and holds the pipeline with stall_o while it iterates.
It returns a registered writeback (reg_waddr_o/reg_we_o/reg_wdata_o) toward exe_mem and forwarding.

Parameters:
XLEN, 32, operand/result width in bits (must be even, >=8)
MUL_FAST, 1, 1 = one-cycle multiply (full product registered); 0 = iterative shift-add multiply, XLEN cycles
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-low (0 = reset), sampled on clk_i rising edge
valid_i  in  1  M-type op presented (opcode INST_TYPE_R_M, funct7 = 0000001)
ready_o  out  1  unit can accept a new op this cycle
funct3_i  in  3  M-op select (MUL=000 … REMU=111)
op1_i  in  XLEN  rs1 value
op2_i  in  XLEN  rs2 value
reg_waddr_i  in  5  destination register
flush_i  in  1  abort in-flight op (branch/exception squash)
stall_o  out  1  request pipeline hold while busy
valid_o  out  1  one-cycle pulse: writeback fields valid
reg_waddr_o  out  5  destination register of completed op
reg_we_o  out  1  write enable (= valid_o, forced 0 when reg_waddr_o = 0)
reg_wdata_o  out  XLEN  result

Behaviour:
- States: IDLE, MUL, DIV, DONE. ready_o = (state==IDLE || state==DONE). stall_o = state is MUL or DIV, or (valid_i && ready_o && !flush_i).
- Reset (rst_i=0 at an edge, any state including mid-op): state IDLE; counter 0; all outputs 0 (ready_o=1 after reset); no valid_o for an aborted op.
- Accept edge E0: valid_i && ready_o && !flush_i. Operands, funct3 and waddr are latched. MUL ops go to MUL; DIV/REM go to DIV.
- Signedness: signs follow the RISC-V rules for each op.
  - MULH: both operands signed. MULHSU: op1 signed, op2 unsigned.
  - DIV/REM: operands converted to magnitudes with sign flags latched.
- MUL_FAST=1: the full 2*XLEN product is registered at E1. State goes DONE; valid_o is high in the cycle after E1.
- MUL_FAST=0: one shift-add step per edge E1..E_XLEN. State goes DONE at E_XLEN; valid_o is high in the cycle after E_XLEN.
- MUL selects low XLEN bits; MULH/MULHSU/MULHU select high XLEN bits.
- Divider: restoring radix-2, one quotient bit per edge E1..E_XLEN. At E_XLEN the sign-corrected quotient/remainder is loaded into reg_wdata_o, state goes DONE, and valid_o is high in the following cycle.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Divide special cases resolve at E1 (latency = 1, same as fast multiply):
  - Divide by zero: quotient = all ones, remainder = dividend (signed and unsigned).
  - Signed overflow (op1 = 1<<(XLEN-1), op2 = -1): quotient = op1, remainder = 0.
- DONE lasts one cycle, then IDLE. A new op may be accepted in DONE (back-to-back); the next op's E0 is the DONE→next edge.
- flush_i=1 at an edge: state goes IDLE and valid_o=0 next cycle. flush_i overrides a simultaneous valid_i and a completing op, so no writeback for either.
- valid_i while busy is ignored. The upstream must hold the op while ready_o=0.
- Outputs are registered and hold their last value except valid_o/reg_we_o, which are cleared outside DONE.

Decomposition:
- defines.v gains:
  - M-op funct3 constants `MD_MUL … `MD_REMU.
  - `FUNCT7_M (0000001).
  - FSM encodings `MD_IDLE/`MD_MUL/`MD_DIV/`MD_DONE.
- Sub-module exe_div_iter owns the restoring-divider datapath:
  - Signals: start, dividend/divisor magnitudes, step enable, quotient/remainder registers, done flag.
  - It is reused if a second divider lane is added.
- The multiplier stays inline (both MUL_FAST branches selected by generate).

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), MUL_FAST=1 -> valid_o 1 cycle after E1 edge, reg_wdata_o=0xFFFFFFEB, reg_we_o=1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF, MUL_FAST=0 -> valid_o after XLEN=32 steps, reg_wdata_o=0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD after 32 steps; REM same operands -> 0xFFFFFFFF; stall_o high throughout, ready_o low.
- DIVU 100 / 0 -> 0xFFFFFFFF at latency 1; REM 0x80000000 / 0xFFFFFFFF -> 0; DIV same -> 0x80000000.
- DIV issued, flush_i pulsed on step 10 -> IDLE next cycle, no valid_o ever, ready_o=1; next MUL 3×4 -> 12 correctly.
- DIVU issued, rst_i=0 on step 5 -> all outputs 0, IDLE; release reset, back-to-back REMU 17/5 then MUL 6×7 accepted in DONE -> 2 then 42, reg_waddr_o tracks each.
